sync_timing_gen: RTL

SYNC_TIMING_GEN -- requirements
Module: sync_timing_gen

---
 rtl/sync_timing_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/sync_timing_gen.sv
// Raster timing generator: pixel/line counters with hsync, vsync, video_on and frame_start.
// Optional Clk-to-pixel prescaler is compiled in when SYNC_TIMING_GEN_PIXDIV_EN is defined.
module sync_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             pixel_tick,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if ((64'(H_TOTAL) > (64'd1 << CNT_W)) || (64'(V_TOTAL) > (64'd1 << CNT_W)) ||
      (CLK_DIV == 0)) begin : gBadConfig
    $error("sync_timing_gen: totals exceed counter range or CLK_DIV is zero");
  end

`ifdef SYNC_TIMING_GEN_PIXDIV_EN
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] prescale;

  assign pixel_tick = Enable && (prescale == DIV_LAST);

  // Prescaler holds while disabled so the pixel phase survives a pause.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prescale <= '0;
    end else if (Enable) begin
      prescale <= pixel_tick ? '0 : prescale + 1'b1;
    end
  end
`else
  assign pixel_tick = Enable;
`endif

  logic [CNT_W-1:0] hNext;
  logic [CNT_W-1:0] vNext;
  logic             frameWrap;
  logic             hsyncNext;
  logic             vsyncNext;
  logic             videoOnNext;

  // Next counter values and their decode, so registered strobes align with the counters.
  always_comb begin
    hNext     = hcount;
    vNext     = vcount;
    frameWrap = 1'b0;
    if (pixel_tick) begin
      if (hcount == H_LAST) begin
        hNext = '0;
        if (vcount == V_LAST) begin
          vNext     = '0;
          frameWrap = 1'b1;
        end else begin
          vNext = vcount + 1'b1;
        end
      end else begin
        hNext = hcount + 1'b1;
      end
    end
    hsyncNext   = ((hNext >= HS_START) && (hNext <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsyncNext   = ((vNext >= VS_START) && (vNext <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    videoOnNext = (hNext < H_VIS) && (vNext < V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hNext;
      vcount      <= vNext;
      hsync       <= hsyncNext;
      vsync       <= vsyncNext;
      video_on    <= videoOnNext;
      frame_start <= frameWrap;
    end
  end

endmodule
